// File: rtl/instruction_memory.sv
// instruction_memory
// Word-indexed 32-bit instruction store for the MIPS fetch stage.
// Reads are purely combinational; a synchronous load port writes program
// words. An asynchronous active-high reset clears every word to NOP (0).
// Indices at or beyond DEPTH never alias: reads return 0, writes are dropped.

module instruction_memory #(
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = 8     // must equal $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   output logic [31:0] Instruction,
   input  logic        WriteEnable,
   input  logic [31:0] WriteAddress,
   input  logic [31:0] WriteData
);

   // Program storage, one 32-bit instruction per word index.
   logic [31:0] mem [DEPTH];

   // Decoded index and range flags for both ports. An index is in range
   // only when every bit above the index field is zero, so large indices
   // (e.g. 0x80000001) can never fold back onto a low word.
   logic [ADDR_BITS-1:0] rd_index;
   logic [ADDR_BITS-1:0] wr_index;
   logic                 rd_in_range;
   logic                 wr_in_range;
   logic                 wr_accept;

   assign rd_index    = Address[ADDR_BITS-1:0];
   assign wr_index    = WriteAddress[ADDR_BITS-1:0];
   assign rd_in_range = (Address[31:ADDR_BITS] == '0);
   assign wr_in_range = (WriteAddress[31:ADDR_BITS] == '0);
   assign wr_accept   = WriteEnable && wr_in_range;

   // Storage update: asynchronous clear of the whole array, else a single
   // word write on the rising edge when the load port targets a valid index.
   // NOTE: this array is deliberately reset word-by-word (a register file,
   // not a RAM macro) because a cleared program must read back as all NOPs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_accept) begin
         // NOTE: non-blocking so every reader of mem sees the pre-edge value
         // within this time step; a blocking write here would race the read.
         mem[wr_index] <= WriteData;
      end
   end

   // Combinational read: out-of-range indices and an active reset both
   // yield NOP; there is no bypass from WriteData.
   always_comb begin
      // NOTE: default first so every path assigns Instruction and no latch
      // is inferred.
      Instruction = '0;
      if (!reset && rd_in_range) begin
         Instruction = mem[rd_index];
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory
// Directed, table-driven bench for instruction_memory: reset state, program
// load and combinational readback, out-of-range handling, read-during-write,
// asynchronous reset mid-program and a full back-to-back fill.

module tb_instruction_memory;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic        WriteEnable;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;

   int n_pass;
   int n_total;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] exp;
   } read_vec_t;

   read_vec_t vecs [7];

   instruction_memory #(
      .DEPTH     (256),
      .ADDR_BITS (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Address      (Address),
      .Instruction  (Instruction),
      .WriteEnable  (WriteEnable),
      .WriteAddress (WriteAddress),
      .WriteData    (WriteData)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_total++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One write through the load port, captured by the next rising edge.
   task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      WriteEnable  = 1'b1;
      WriteAddress = addr;
      WriteData    = data;
      @(posedge clk);
      #1;
      WriteEnable  = 1'b0;
   endtask

   // Set the read index and sample after a short settle, with no clock edge.
   task automatic read_check(input string name, input logic [31:0] addr,
                             input logic [31:0] expected);
      Address = addr;
      #1;
      check(name, Instruction, expected);
   endtask

   initial begin
      vecs[0] = '{"rd_word0",       32'd0,          32'h8C08_0000};
      vecs[1] = '{"rd_word1",       32'd1,          32'h8C09_0004};
      vecs[2] = '{"rd_word7",       32'd7,          32'h0109_5020};
      vecs[3] = '{"rd_word2_empty", 32'd2,          32'h0000_0000};
      vecs[4] = '{"rd_oob_256",     32'd256,        32'h0000_0000};
      vecs[5] = '{"rd_word0_again", 32'd0,          32'h8C08_0000};
      vecs[6] = '{"rd_no_alias",    32'h8000_0001,  32'h0000_0000};

      n_pass       = 0;
      n_total      = 0;
      reset        = 1'b1;
      Address      = '0;
      WriteEnable  = 1'b0;
      WriteAddress = '0;
      WriteData    = '0;

      // Reset state and reset-then-sweep with no write activity.
      #12;
      check("during_reset", Instruction, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      foreach (vecs[i]) begin
         if (i < 1) begin
            read_check("sweep_0", 32'd0, 32'h0);
            #19;
            read_check("sweep_1", 32'd1, 32'h0);
            #19;
            read_check("sweep_7", 32'd7, 32'h0);
            #19;
            read_check("sweep_255", 32'd255, 32'h0);
         end
      end

      // Program load, plus a write to an out-of-range index that must drop.
      write_word(32'd0,   32'h8C08_0000);
      write_word(32'd1,   32'h8C09_0004);
      write_word(32'd7,   32'h0109_5020);
      write_word(32'd256, 32'hDEAD_BEEF);

      // Table-driven combinational readback.
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end

      // Read-during-write to the same index: old word before, new after.
      write_word(32'd3, 32'h1111_1111);
      @(negedge clk);
      Address      = 32'd3;
      WriteEnable  = 1'b1;
      WriteAddress = 32'd3;
      WriteData    = 32'h2222_2222;
      #1;
      check("rdw_before_edge", Instruction, 32'h1111_1111);
      @(posedge clk);
      #1;
      WriteEnable = 1'b0;
      check("rdw_after_edge", Instruction, 32'h2222_2222);

      // Asynchronous reset mid-program.
      @(negedge clk);
      read_check("pre_reset_word1", 32'd1, 32'h8C09_0004);
      #1;
      reset = 1'b1;
      #1;
      check("async_clear_word1", Instruction, 32'h0);
      // Write strobed across an edge while reset is still high.
      WriteEnable  = 1'b1;
      WriteAddress = 32'd0;
      WriteData    = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      WriteEnable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      read_check("post_reset_word0", 32'd0, 32'h0);
      read_check("post_reset_word1", 32'd1, 32'h0);
      read_check("post_reset_word7", 32'd7, 32'h0);

      // First edge after deassertion accepts a write.
      WriteEnable  = 1'b1;
      WriteAddress = 32'd5;
      WriteData    = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      WriteEnable = 1'b0;
      read_check("first_write_after_reset", 32'd5, 32'h0BAD_F00D);

      // Back-to-back fill of every index, one write per edge.
      @(negedge clk);
      WriteEnable = 1'b1;
      for (int i = 0; i < 256; i++) begin
         WriteAddress = i;
         WriteData    = i * 32'h0101_0101;
         @(negedge clk);
      end
      WriteEnable = 1'b0;
      for (int i = 0; i < 256; i++) begin
         read_check($sformatf("fill_%0d", i), i, i * 32'h0101_0101);
      end
      read_check("fill_oob_256", 32'd256, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
